// File: rtl/register_exchange_unit.sv
// register_exchange_unit: bank of NUM_REGS x WIDTH registers with load, swap,
// clear and a multi-cycle rotate engine behind a valid/ready command port.
`default_nettype none

module register_exchange_unit #(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 4,
   parameter int IDX_W    = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [2:0]                cmd_op,
   input  logic [IDX_W-1:0]          cmd_idx_a,
   input  logic [IDX_W-1:0]          cmd_idx_b,
   input  logic [IDX_W-1:0]          cmd_amount,
   input  logic [WIDTH-1:0]          cmd_data,
   output logic [NUM_REGS*WIDTH-1:0] regs_flat,
   output logic                      busy,
   output logic                      done,
   output logic                      error
);

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_SWAP  = 3'd2;
   localparam logic [2:0] OP_ROTL  = 3'd3;
   localparam logic [2:0] OP_ROTR  = 3'd4;
   localparam logic [2:0] OP_CLEAR = 3'd5;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ROTATE = 1'b1
   } state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] regs      [NUM_REGS];
   logic [WIDTH-1:0] next_regs [NUM_REGS];
   logic [WIDTH-1:0] rot_l     [NUM_REGS];
   logic [WIDTH-1:0] rot_r     [NUM_REGS];
   logic [IDX_W-1:0] remaining, next_remaining;
   logic             rot_left, next_rot_left;
   logic             next_done, next_error;
   logic             a_ok, b_ok, amt_ok;
   logic [WIDTH-1:0] val_a, val_b;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == ROTATE);

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[gi*WIDTH +: WIDTH] = regs[gi];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         rot_left  <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         state     <= next_state;
         remaining <= next_remaining;
         rot_left  <= next_rot_left;
         done      <= next_done;
         error     <= next_error;
         regs      <= next_regs;
      end
   end

   always_comb begin
      next_state     = state;
      next_regs      = regs;
      next_remaining = remaining;
      next_rot_left  = rot_left;
      next_done      = 1'b0;
      next_error     = 1'b0;
      a_ok           = (int'(cmd_idx_a) < NUM_REGS);
      b_ok           = (int'(cmd_idx_b) < NUM_REGS);
      amt_ok         = (int'(cmd_amount) < NUM_REGS);
      val_a          = '0;
      val_b          = '0;
      // Single-step rotations of the pre-edge bank; every update reads old values only.
      for (int i = 0; i < NUM_REGS; i++) begin
         rot_l[i] = regs[(i + NUM_REGS - 1) % NUM_REGS];
         rot_r[i] = regs[(i + 1) % NUM_REGS];
         if (int'(cmd_idx_a) == i) val_a = regs[i];
         if (int'(cmd_idx_b) == i) val_b = regs[i];
      end

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_NOP: ;
                  OP_LOAD: begin
                     if (a_ok) begin
                        for (int i = 0; i < NUM_REGS; i++)
                           if (int'(cmd_idx_a) == i) next_regs[i] = cmd_data;
                        next_done = 1'b1;
                     end else begin
                        next_error = 1'b1;
                     end
                  end
                  OP_SWAP: begin
                     if (a_ok && b_ok) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                           if (int'(cmd_idx_a) == i) next_regs[i] = val_b;
                           if (int'(cmd_idx_b) == i) next_regs[i] = val_a;
                        end
                        next_done = 1'b1;
                     end else begin
                        next_error = 1'b1;
                     end
                  end
                  OP_ROTL, OP_ROTR: begin
                     if (!amt_ok) begin
                        next_error = 1'b1;
                     end else if (cmd_amount == '0) begin
                        next_done = 1'b1;
                     end else begin
                        if (cmd_op == OP_ROTL) next_regs = rot_l;
                        else                   next_regs = rot_r;
                        next_rot_left  = (cmd_op == OP_ROTL);
                        next_remaining = cmd_amount - IDX_W'(1);
                        if (cmd_amount == IDX_W'(1)) next_done  = 1'b1;
                        else                         next_state = ROTATE;
                     end
                  end
                  OP_CLEAR: begin
                     for (int i = 0; i < NUM_REGS; i++) next_regs[i] = '0;
                     next_done = 1'b1;
                  end
                  default: next_error = 1'b1;
               endcase
            end
         end
         ROTATE: begin
            if (rot_left) next_regs = rot_l;
            else          next_regs = rot_r;
            next_remaining = remaining - IDX_W'(1);
            if (remaining == IDX_W'(1)) begin
               next_state = IDLE;
               next_done  = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_register_exchange_unit.sv
// Bench for register_exchange_unit: constant vector table, hand-written corner
// sequences, then random commands against an arithmetic reference model.
`default_nettype none

module tb_register_exchange_unit;

   localparam int N = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [2:0]  cmd_idx_a, cmd_idx_b, cmd_amount;
   logic [7:0]  cmd_data;
   logic [31:0] regs_flat;
   logic        busy, done, error;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0] m [N];

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  a;
      logic [2:0]  b;
      logic [2:0]  amt;
      logic [7:0]  data;
      logic [31:0] flat;
      logic        dn;
      logic        er;
      int          lat;
   } vec_t;

   vec_t tbl[$];

   always #5 clock = ~clock;

   register_exchange_unit #(.WIDTH(8), .NUM_REGS(N), .IDX_W(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_idx_a  (cmd_idx_a),
      .cmd_idx_b  (cmd_idx_b),
      .cmd_amount (cmd_amount),
      .cmd_data   (cmd_data),
      .regs_flat  (regs_flat),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: whole-command effect computed with modular index arithmetic.
   task automatic model_cmd(input logic [2:0] op, a, b, amt, input logic [7:0] d,
                            output logic [31:0] flat, output logic e_done, e_err,
                            output int lat);
      logic [7:0] old [N];
      lat = 1; e_done = 1'b0; e_err = 1'b0;
      for (int i = 0; i < N; i++) old[i] = m[i];
      case (op)
         3'd0: ;
         3'd1: if (a >= N) e_err = 1'b1; else begin m[a] = d; e_done = 1'b1; end
         3'd2: if (a >= N || b >= N) e_err = 1'b1;
               else begin m[a] = old[b]; m[b] = old[a]; e_done = 1'b1; end
         3'd3, 3'd4: begin
            if (amt >= N) e_err = 1'b1;
            else begin
               for (int i = 0; i < N; i++)
                  if (op == 3'd3) m[(i + amt) % N] = old[i];
                  else            m[i] = old[(i + amt) % N];
               lat = (amt == 0) ? 1 : int'(amt);
               e_done = 1'b1;
            end
         end
         3'd5: begin for (int i = 0; i < N; i++) m[i] = 8'h00; e_done = 1'b1; end
         default: e_err = 1'b1;
      endcase
      for (int i = 0; i < N; i++) flat[i*8 +: 8] = m[i];
   endtask

   task automatic drive(input logic [2:0] op, a, b, amt, input logic [7:0] d);
      cmd_valid = 1'b1; cmd_op = op; cmd_idx_a = a; cmd_idx_b = b;
      cmd_amount = amt; cmd_data = d;
   endtask

   task automatic run_and_check(input logic [2:0] op, a, b, amt, input logic [7:0] d,
                                input logic [31:0] e_flat, input logic e_done, e_err,
                                input int lat, input string name);
      int guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(posedge clock); #1; guard++;
      end
      if (!cmd_ready) check({name, " ready-timeout"}, 64'(cmd_ready), 64'd1);
      @(negedge clock);
      drive(op, a, b, amt, d);
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      for (int c = 1; c < lat; c++) begin
         check({name, " busy"}, 64'(busy), 64'd1);
         check({name, " early-done"}, 64'(done), 64'd0);
         @(posedge clock); #1;
      end
      check({name, " regs"}, 64'(regs_flat), 64'(e_flat));
      check({name, " done"}, 64'(done), 64'(e_done));
      check({name, " error"}, 64'(error), 64'(e_err));
      check({name, " busy-end"}, 64'(busy), 64'd0);
      @(posedge clock); #1;
      check({name, " pulse"}, 64'({done, error}), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ef;
      logic        ed, ee;
      int          el;

      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_idx_a = '0; cmd_idx_b = '0;
      cmd_amount = '0; cmd_data = '0;
      for (int i = 0; i < N; i++) m[i] = 8'h00;
      #12;
      check("reset regs", 64'(regs_flat), 64'd0);
      check("reset flags", 64'({busy, done, error}), 64'd0);
      @(negedge clock); reset = 1'b0; #1;
      check("ready after reset", 64'(cmd_ready), 64'd1);

      //                 op    a     b     amt   data   flat          dn    er   lat
      tbl.push_back(vec_t'{3'd1, 3'd0, 3'd0, 3'd0, 8'h11, 32'h00000011, 1'b1, 1'b0, 1});
      tbl.push_back(vec_t'{3'd1, 3'd1, 3'd0, 3'd0, 8'h22, 32'h00002211, 1'b1, 1'b0, 1});
      tbl.push_back(vec_t'{3'd1, 3'd2, 3'd0, 3'd0, 8'h33, 32'h00332211, 1'b1, 1'b0, 1});
      tbl.push_back(vec_t'{3'd1, 3'd3, 3'd0, 3'd0, 8'h44, 32'h44332211, 1'b1, 1'b0, 1});
      tbl.push_back(vec_t'{3'd2, 3'd0, 3'd3, 3'd0, 8'h00, 32'h11332244, 1'b1, 1'b0, 1});
      tbl.push_back(vec_t'{3'd2, 3'd2, 3'd2, 3'd0, 8'h00, 32'h11332244, 1'b1, 1'b0, 1});
      tbl.push_back(vec_t'{3'd2, 3'd3, 3'd0, 3'd0, 8'h00, 32'h44332211, 1'b1, 1'b0, 1});
      tbl.push_back(vec_t'{3'd3, 3'd0, 3'd0, 3'd3, 8'h00, 32'h11443322, 1'b1, 1'b0, 3});
      tbl.push_back(vec_t'{3'd4, 3'd0, 3'd0, 3'd3, 8'h00, 32'h44332211, 1'b1, 1'b0, 3});
      tbl.push_back(vec_t'{3'd4, 3'd0, 3'd0, 3'd1, 8'h00, 32'h11443322, 1'b1, 1'b0, 1});
      tbl.push_back(vec_t'{3'd4, 3'd0, 3'd0, 3'd0, 8'h00, 32'h11443322, 1'b1, 1'b0, 1});
      tbl.push_back(vec_t'{3'd3, 3'd0, 3'd0, 3'd1, 8'h00, 32'h44332211, 1'b1, 1'b0, 1});
      tbl.push_back(vec_t'{3'd1, 3'd5, 3'd0, 3'd0, 8'hAA, 32'h44332211, 1'b0, 1'b1, 1});
      tbl.push_back(vec_t'{3'd7, 3'd0, 3'd0, 3'd0, 8'h00, 32'h44332211, 1'b0, 1'b1, 1});
      tbl.push_back(vec_t'{3'd6, 3'd1, 3'd2, 3'd1, 8'h00, 32'h44332211, 1'b0, 1'b1, 1});
      tbl.push_back(vec_t'{3'd3, 3'd0, 3'd0, 3'd4, 8'h00, 32'h44332211, 1'b0, 1'b1, 1});
      tbl.push_back(vec_t'{3'd4, 3'd0, 3'd0, 3'd7, 8'h00, 32'h44332211, 1'b0, 1'b1, 1});
      tbl.push_back(vec_t'{3'd2, 3'd1, 3'd6, 3'd0, 8'h00, 32'h44332211, 1'b0, 1'b1, 1});
      tbl.push_back(vec_t'{3'd0, 3'd1, 3'd2, 3'd3, 8'h55, 32'h44332211, 1'b0, 1'b0, 1});
      tbl.push_back(vec_t'{3'd5, 3'd0, 3'd0, 3'd0, 8'h00, 32'h00000000, 1'b1, 1'b0, 1});

      foreach (tbl[i])
         run_and_check(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].amt, tbl[i].data,
                       tbl[i].flat, tbl[i].dn, tbl[i].er, tbl[i].lat,
                       $sformatf("vec%0d", i));

      // A command held on cmd_valid through a rotate is taken only once ready returns.
      run_and_check(3'd1, 3'd0, 3'd0, 3'd0, 8'h11, 32'h00000011, 1'b1, 1'b0, 1, "ldA0");
      run_and_check(3'd1, 3'd1, 3'd0, 3'd0, 8'h22, 32'h00002211, 1'b1, 1'b0, 1, "ldA1");
      run_and_check(3'd1, 3'd2, 3'd0, 3'd0, 8'h33, 32'h00332211, 1'b1, 1'b0, 1, "ldA2");
      run_and_check(3'd1, 3'd3, 3'd0, 3'd0, 8'h44, 32'h44332211, 1'b1, 1'b0, 1, "ldA3");
      @(negedge clock);
      drive(3'd3, 3'd0, 3'd0, 3'd3, 8'h00);
      @(posedge clock); #1;
      drive(3'd1, 3'd0, 3'd0, 3'd0, 8'hFF);
      for (int c = 1; c < 3; c++) begin
         check("held busy", 64'({busy, cmd_ready}), 64'b10);
         check("held no-done", 64'(done), 64'd0);
         @(posedge clock); #1;
      end
      check("held rotl3 regs", 64'(regs_flat), 64'h11443322);
      check("held rotl3 done", 64'({done, busy, cmd_ready}), 64'b101);
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      check("held load regs", 64'(regs_flat), 64'h114433FF);
      check("held load done", 64'(done), 64'd1);

      // Asynchronous reset in the middle of a rotate.
      @(negedge clock);
      drive(3'd3, 3'd0, 3'd0, 3'd3, 8'h00);
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      @(posedge clock); #3;
      reset = 1'b1; #1;
      check("midrot reset regs", 64'(regs_flat), 64'd0);
      check("midrot reset busy", 64'({busy, done}), 64'd0);
      @(posedge clock); #1;
      check("midrot reset hold", 64'({done, error, regs_flat}), 64'd0);
      @(negedge clock); reset = 1'b0; #1;
      check("midrot ready", 64'(cmd_ready), 64'd1);
      repeat (3) begin
         @(posedge clock); #1;
         check("midrot no-done", 64'({done, busy}), 64'd0);
      end

      for (int i = 0; i < N; i++) m[i] = 8'h00;
      for (int n = 0; n < 200; n++) begin
         logic [2:0] op, a, b, amt;
         logic [7:0] d;
         op  = 3'($urandom_range(0, 7));
         a   = 3'($urandom_range(0, 7));
         b   = ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7));
         amt = 3'($urandom_range(0, 7));
         d   = 8'($urandom);
         model_cmd(op, a, b, amt, d, ef, ed, ee, el);
         run_and_check(op, a, b, amt, d, ef, ed, ee, el, $sformatf("rnd%0d op%0d", n, op));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
